// File: rtl/pc_pkg.sv
// Shared select encodings for the program-counter sequencer.
package pc_pkg;

  localparam int unsigned PCSEL_W = 3;

  localparam logic [PCSEL_W-1:0] PCSEL_SEQ = 3'd0;
  localparam logic [PCSEL_W-1:0] PCSEL_BR  = 3'd1;
  localparam logic [PCSEL_W-1:0] PCSEL_J   = 3'd2;
  localparam logic [PCSEL_W-1:0] PCSEL_JR  = 3'd3;
  localparam logic [PCSEL_W-1:0] PCSEL_RET = 3'd4;

endpackage

// File: rtl/pc_sequencer_return_stack.sv
// Circular return-address stack. Push writes at top+1; pop exposes mem[top].
// A full stack silently overwrites its oldest entry; pop+push replaces the top.
module return_stack #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top_data,
  output logic             empty,
  output logic             ovf,
  output logic             udf
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] top;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             replace;
  logic             wr_en;
  logic [PTR_W-1:0] wr_ptr;

  assign empty    = (count == '0);
  assign full     = (count == CNT_FULL);
  assign top_data = mem[top];

  // Pop+push on a non-empty stack rewrites the top in place; on an empty
  // stack the pop underflows and the push proceeds as an ordinary push.
  assign replace = push && pop && !empty;
  assign udf     = pop && empty;
  assign ovf     = push && !pop && full;
  assign wr_en   = push && !reset;
  assign wr_ptr  = replace ? top : top + PTR_ONE;

  // Entry storage; contents are don't-care once count is cleared.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Top pointer and occupancy count.
  always_ff @(posedge clock) begin
    if (reset) begin
      top   <= '0;
      count <= '0;
    end else if (replace) begin
      top   <= top;
      count <= count;
    end else if (push) begin
      top <= top + PTR_ONE;
      if (!full) begin
        count <= count + CNT_ONE;
      end
    end else if (pop && !empty) begin
      top   <= top - PTR_ONE;
      count <= count - CNT_ONE;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Registered program counter with next-PC select, stall, return-address
// stack and sticky error flags.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter int unsigned      RAS_DEPTH = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               stall,
  input  logic [PCSEL_W-1:0] mux_pc,
  input  logic [WIDTH-1:0]   immediate,
  input  logic [WIDTH-1:0]   address,
  input  logic [WIDTH-1:0]   data,
  input  logic               push_ra,
  output logic [WIDTH-1:0]   pc,
  output logic [WIDTH-1:0]   pc_plus1,
  output logic               ras_empty,
  output logic               ras_overflow,
  output logic               ras_underflow,
  output logic               illegal_sel
);

  localparam logic [WIDTH-1:0] ONE = 1;

  logic [WIDTH-1:0] next_pc;
  logic [WIDTH-1:0] ras_top;
  logic             ras_push;
  logic             ras_pop;
  logic             ras_ovf;
  logic             ras_udf;
  logic             sel_illegal;

  assign pc_plus1 = pc + ONE;
  assign ras_push = push_ra && !stall;
  assign ras_pop  = (mux_pc == PCSEL_RET) && !stall;

  return_stack #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock     (clock),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_plus1),
    .top_data  (ras_top),
    .empty     (ras_empty),
    .ovf       (ras_ovf),
    .udf       (ras_udf)
  );

  // Next-PC select; an empty-stack return falls back to the register target.
  always_comb begin
    next_pc     = pc;
    sel_illegal = 1'b0;
    case (mux_pc)
      PCSEL_SEQ: next_pc = pc_plus1;
      PCSEL_BR:  next_pc = pc_plus1 + immediate;
      PCSEL_J:   next_pc = address;
      PCSEL_JR:  next_pc = data;
      PCSEL_RET: next_pc = ras_empty ? data : ras_top;
      default:   sel_illegal = 1'b1;
    endcase
  end

  // PC register; stall freezes it.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (!stall) begin
      pc <= next_pc;
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
      illegal_sel   <= 1'b0;
    end else if (!stall) begin
      ras_overflow  <= ras_overflow  | ras_ovf;
      ras_underflow <= ras_underflow | ras_udf;
      illegal_sel   <= illegal_sel   | sel_illegal;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer with hand-computed expectations.
module tb_pc_sequencer;
  import pc_pkg::*;

  logic               clock = 1'b0;
  logic               reset;
  logic               stall;
  logic [PCSEL_W-1:0] mux_pc;
  logic [31:0]        immediate;
  logic [31:0]        address;
  logic [31:0]        data;
  logic               push_ra;
  logic [31:0]        pc;
  logic [31:0]        pc_plus1;
  logic               ras_empty;
  logic               ras_overflow;
  logic               ras_underflow;
  logic               illegal_sel;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  pc_sequencer #(
    .WIDTH     (32),
    .RESET_PC  (32'h0),
    .RAS_DEPTH (8)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .stall         (stall),
    .mux_pc        (mux_pc),
    .immediate     (immediate),
    .address       (address),
    .data          (data),
    .push_ra       (push_ra),
    .pc            (pc),
    .pc_plus1      (pc_plus1),
    .ras_empty     (ras_empty),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow),
    .illegal_sel   (illegal_sel)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
    end
  endtask

  // One clock edge, then settle before sampling.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [2:0] sel, input logic push, input logic [31:0] addr);
    mux_pc  = sel;
    push_ra = push;
    address = addr;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; mux_pc = PCSEL_SEQ; push_ra = 1'b0;
    immediate = '0; address = '0; data = '0;

    // 1: reset state, sequential fetch, mid-run reset
    step();
    check("rst_pc", pc, 32'h0);
    check("rst_empty", {31'b0, ras_empty}, 32'h1);
    check("rst_flags", {29'b0, ras_overflow, ras_underflow, illegal_sel}, 32'h0);
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      check("seq_pc", pc, 32'(i));
    end
    check("seq_plus1", pc_plus1, 32'h4);
    reset = 1'b1;
    step();
    check("midrst_pc", pc, 32'h0);
    reset = 1'b0;

    // 2: branch, jump, register target
    drive(PCSEL_J, 1'b0, 32'd10); step();
    check("j10", pc, 32'd10);
    immediate = 32'hFFFF_FFFD;
    drive(PCSEL_BR, 1'b0, 32'h0); step();
    check("br_m3", pc, 32'd8);
    drive(PCSEL_J, 1'b0, 32'h40); step();
    check("j40", pc, 32'h40);
    data = 32'h99;
    drive(PCSEL_JR, 1'b0, 32'h0); step();
    check("jr99", pc, 32'h99);

    // 3: nested call/return
    drive(PCSEL_J, 1'b0, 32'd5); step();
    drive(PCSEL_J, 1'b1, 32'h20); step();
    check("call1_pc", pc, 32'h20);
    check("call1_empty", {31'b0, ras_empty}, 32'h0);
    drive(PCSEL_J, 1'b1, 32'h30); step();
    check("call2_pc", pc, 32'h30);
    drive(PCSEL_RET, 1'b0, 32'h0); step();
    check("ret1_pc", pc, 32'h21);
    step();
    check("ret2_pc", pc, 32'd6);
    check("ret_empty", {31'b0, ras_empty}, 32'h1);
    check("ret_udf", {31'b0, ras_underflow}, 32'h0);

    // 4: overflow and underflow at depth 8
    reset = 1'b1; step(); reset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive(PCSEL_SEQ, 1'b1, 32'h0); step();
    end
    check("ovf_pc", pc, 32'd9);
    check("ovf_flag", {31'b0, ras_overflow}, 32'h1);
    data = 32'h777;
    for (int i = 0; i < 8; i++) begin
      drive(PCSEL_RET, 1'b0, 32'h0); step();
      check("ovf_ret", pc, 32'(9 - i));
    end
    check("ovf_noudf", {31'b0, ras_underflow}, 32'h0);
    step();
    check("udf_pc", pc, 32'h777);
    check("udf_flag", {31'b0, ras_underflow}, 32'h1);
    check("udf_empty", {31'b0, ras_empty}, 32'h1);

    // 5: stall holds everything
    reset = 1'b1; step(); reset = 1'b0;
    stall = 1'b1;
    drive(PCSEL_J, 1'b1, 32'h50);
    step(); step();
    check("stall_pc", pc, 32'h0);
    check("stall_empty", {31'b0, ras_empty}, 32'h1);
    stall = 1'b0; step();
    check("unstall_pc", pc, 32'h50);
    drive(PCSEL_RET, 1'b0, 32'h0); step();
    check("unstall_ret", pc, 32'h1);
    check("unstall_one", {31'b0, ras_empty}, 32'h1);

    // 6: wrap-around and illegal select
    drive(PCSEL_J, 1'b0, 32'hFFFF_FFFF); step();
    drive(PCSEL_SEQ, 1'b0, 32'h0); step();
    check("wrap_pc", pc, 32'h0);
    stall = 1'b1; drive(3'd6, 1'b0, 32'h0); step();
    check("ill_stalled", {31'b0, illegal_sel}, 32'h0);
    stall = 1'b0; step();
    check("ill_pc", pc, 32'h0);
    check("ill_flag", {31'b0, illegal_sel}, 32'h1);
    drive(PCSEL_SEQ, 1'b0, 32'h0); step();
    check("ill_sticky", {31'b0, illegal_sel}, 32'h1);
    check("ill_seq_pc", pc, 32'h1);
    reset = 1'b1; step(); reset = 1'b0;
    check("ill_clear", {31'b0, illegal_sel}, 32'h0);

    // 7: simultaneous pop and push
    drive(PCSEL_SEQ, 1'b1, 32'h0); step();
    drive(PCSEL_J, 1'b0, 32'h10); step();
    drive(PCSEL_RET, 1'b1, 32'h0); step();
    check("pp_pc", pc, 32'h1);
    check("pp_empty", {31'b0, ras_empty}, 32'h0);
    drive(PCSEL_RET, 1'b0, 32'h0); step();
    check("pp_ret", pc, 32'h11);
    check("pp_udf0", {31'b0, ras_underflow}, 32'h0);
    data = 32'h33;
    drive(PCSEL_RET, 1'b1, 32'h0); step();
    check("ppe_pc", pc, 32'h33);
    check("ppe_udf", {31'b0, ras_underflow}, 32'h1);
    check("ppe_empty", {31'b0, ras_empty}, 32'h0);
    drive(PCSEL_RET, 1'b0, 32'h0); step();
    check("ppe_ret", pc, 32'h12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
